// File: rtl/branch_stall_sequencer.sv
// branch_stall_sequencer
// Owns the PC write path whenever core_control asks for a stall:
// POP wait, forward bracket scan on a taken CBF, and jump-back on a taken CBB.
// The core control bundle is gated (core_en=0) while a sequence is running.
// Optional build macro: STALL_PERF_EN adds a saturating 32-bit stall_cycles counter.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal execution, PC advances on every ready instruction
// POP_WAIT | one-cycle bubble after a stalled POP, then PC+1
// SCAN     | walking forward from CBF looking for the matching CBB
// RESUME   | one-cycle jump back to the latched loop-start PC

package bss_pkg;
   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_INC   = 4'd1,
      OP_DEC   = 4'd2,
      OP_LEFT  = 4'd3,
      OP_RIGHT = 4'd4,
      OP_OUT   = 4'd5,
      OP_IN    = 4'd6,
      OP_CBF   = 4'd7,
      OP_CBB   = 4'd8,
      OP_POP   = 4'd9
   } op_code;
endpackage

module branch_stall_sequencer
   import bss_pkg::*;
#(
   parameter int PC_W    = 16,
   parameter int DEPTH_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  op_code          instr,
   input  logic            imem_ready,
   input  logic            req_stall,
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] cache_pc,
   output logic [PC_W-1:0] fetch_addr,
   output logic            pc_write,
   output logic [PC_W-1:0] pc_next,
   output logic            core_en,
   output logic            busy,
   output logic            scan_err,
   output logic [1:0]      seq_state
`ifdef STALL_PERF_EN
   ,
   output logic [31:0]     stall_cycles
`endif
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      POP_WAIT = 2'd1,
      SCAN     = 2'd2,
      RESUME   = 2'd3
   } seq_t;

   localparam logic [PC_W-1:0]    PC_MAX    = '1;
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
   localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

   seq_t               state;
   logic [DEPTH_W-1:0] depth;
   logic [PC_W-1:0]    scan_pc;
   logic [PC_W-1:0]    ret_pc;
   logic               err_q;

   logic run_ready;
   logic stall_pop;
   logic stall_cbf;
   logic stall_cbb;
   logic scan_live;
   logic scan_match;
   logic scan_ovf;
   logic scan_wrap;

   // Decode of the events that drive both the outputs and the next state.
   // An errored scan is frozen, so it never counts as a live scan cycle.
   always_comb begin
      run_ready  = (state == RUN) && imem_ready;
      stall_pop  = run_ready && req_stall && (instr == OP_POP);
      stall_cbf  = run_ready && req_stall && (instr == OP_CBF);
      stall_cbb  = run_ready && req_stall && (instr == OP_CBB);
      scan_live  = (state == SCAN) && !err_q && imem_ready;
      scan_match = scan_live && (instr == OP_CBB) && (depth == DEPTH_ONE);
      scan_ovf   = scan_live && (instr == OP_CBF) && (depth == DEPTH_MAX);
      scan_wrap  = scan_live && !scan_match && (scan_pc == PC_MAX);
   end

   // Output decode; everything is forced quiet while reset is asserted so the
   // PC is never written on a reset cycle, even mid-sequence.
   always_comb begin
      fetch_addr = (state == SCAN) ? scan_pc : pc;
      pc_next    = pc + PC_W'(1);
      pc_write   = 1'b0;
      core_en    = 1'b0;
      if (!reset) begin
         case (state)
            RUN: begin
               core_en  = imem_ready;
               pc_write = imem_ready &&
                          !(req_stall && ((instr == OP_POP) ||
                                          (instr == OP_CBF) ||
                                          (instr == OP_CBB)));
            end
            POP_WAIT: begin
               pc_write = 1'b1;
            end
            SCAN: begin
               pc_next  = scan_pc + PC_W'(1);
               pc_write = scan_match;
            end
            RESUME: begin
               pc_next  = ret_pc;
               pc_write = 1'b1;
            end
            default: begin
               pc_write = 1'b0;
            end
         endcase
      end
      busy      = !reset && (state != RUN);
      scan_err  = !reset && err_q;
      seq_state = reset ? 2'd0 : state;
   end

   // Sequencer state, bracket depth, scan pointer and sticky error.
   // A CBF taken at the top of PC space has nowhere to scan, so it errors at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RUN;
         depth   <= '0;
         scan_pc <= '0;
         ret_pc  <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (stall_pop) begin
                  state <= POP_WAIT;
               end else if (stall_cbf) begin
                  state   <= SCAN;
                  scan_pc <= pc + PC_W'(1);
                  depth   <= DEPTH_ONE;
                  if (pc == PC_MAX) err_q <= 1'b1;
               end else if (stall_cbb) begin
                  state  <= RESUME;
                  ret_pc <= cache_pc;
               end
            end
            POP_WAIT: state <= RUN;
            RESUME:   state <= RUN;
            SCAN: begin
               if (scan_live) begin
                  if (scan_ovf || scan_wrap) begin
                     err_q <= 1'b1;
                  end else if (scan_match) begin
                     state <= RUN;
                  end else begin
                     scan_pc <= scan_pc + PC_W'(1);
                     if (instr == OP_CBF)      depth <= depth + DEPTH_ONE;
                     else if (instr == OP_CBB) depth <= depth - DEPTH_ONE;
                  end
               end
            end
            default: state <= RUN;
         endcase
      end
   end

`ifdef STALL_PERF_EN
   // Count every cycle the core is not making forward progress; saturates.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (((state != RUN) || !imem_ready) && (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule
